dose_scheduler: RTL

//  Multi-channel successor to the fixed 08:00/13:00/20:00 dispense-time logic.
//  - Holds a programmable table of up to SLOTS dose times for each of NCH dispenser channels.
//  - Compares the table against the running 24 h clock.
//  - Queues due doses and drives one actuator pulse at a time.
//  - Sits between the hour/minute/second counters and the GPIO dispenser outputs.

---
 rtl/dose_pkg.sv | 34 +++
 rtl/dose_slot_match.sv | 55 +++++
 rtl/dose_scheduler.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/dose_pkg.sv
// dose_pkg: shared widths, time limits, table entry layout and FSM state
// encoding for the dose scheduler.
//   HOUR_W/MIN_W/SEC_W  widths of the hour/minute/second time inputs
//   HOURS_PER_DAY       first illegal hour value (24)
//   MIN_PER_HOUR        first illegal minute value (60)
//   slot_t              one schedule table entry {en, hour, min}
//   state_t             pulse FSM states
//   idx_w()             index width for an N-entry select, never below 1
package dose_pkg;

    localparam int HOUR_W = 5;
    localparam int MIN_W  = 6;
    localparam int SEC_W  = 6;

    localparam logic [HOUR_W-1:0] HOURS_PER_DAY = 5'd24;
    localparam logic [MIN_W-1:0]  MIN_PER_HOUR  = 6'd60;

    typedef struct packed {
        logic              en;
        logic [HOUR_W-1:0] hour;
        logic [MIN_W-1:0]  min;
    } slot_t;

    typedef enum logic [1:0] {
        IDLE,
        PULSE,
        GAP
    } state_t;

    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/dose_slot_match.sv
// dose_slot_match: schedule table for one dispenser channel.
// Holds SLOTS entries, applies range-checked writes, and flags (combinationally,
// from the stored table) when any enabled entry equals the current hour:minute.
// Ports:
//   clk, reset     clock, synchronous active-high reset (clears all entries)
//   we             write strobe, already qualified with this channel's select
//   slot           entry index to write
//   en/hour/min    entry contents to write
//   hours/minutes  current time of day
//   due            some enabled entry matches the current time (unqualified by sec_tick)
module dose_slot_match
    import dose_pkg::*;
#(
    parameter int unsigned SLOTS  = 3,
    parameter int unsigned SLOT_W = idx_w(SLOTS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [SLOT_W-1:0] slot,
    input  logic              en,
    input  logic [HOUR_W-1:0] hour,
    input  logic [MIN_W-1:0]  min,
    input  logic [HOUR_W-1:0] hours,
    input  logic [MIN_W-1:0]  minutes,
    output logic              due
);

    slot_t tbl [SLOTS];
    logic  write_ok;

    assign write_ok = we && (32'(slot) < SLOTS) &&
                      (hour < HOURS_PER_DAY) && (min < MIN_PER_HOUR);

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < SLOTS; i++) begin
                tbl[i] <= '0;
            end
        end else if (write_ok) begin
            tbl[slot] <= {en, hour, min};
        end
    end

    // Reads the registered table, so a same-cycle write never affects the match.
    always_comb begin
        due = 1'b0;
        for (int unsigned i = 0; i < SLOTS; i++) begin
            if (tbl[i].en && (tbl[i].hour == hours) && (tbl[i].min == minutes)) begin
                due = 1'b1;
            end
        end
    end

endmodule

// File: rtl/dose_scheduler.sv
// dose_scheduler: multi-channel dose timing. Compares per-channel schedule
// tables against the 24 h clock at each new minute, queues due doses as
// pending bits, counts doses that arrive while one is still queued, and
// serves the queue round-robin with one actuator pulse at a time followed
// by a one-cycle settle gap.
// Ports:
//   CLOCK_50, reset            clock, synchronous active-high reset
//   sec_tick                   one-cycle pulse; time inputs hold the new second
//   hours/minutes/seconds      current time of day
//   cfg_we/cfg_ch/cfg_slot     table write strobe and address
//   cfg_en/cfg_hour/cfg_min    table write data
//   manual_req                 level manual dispense requests
//   dispense                   one-hot actuator drive
//   busy                       actuator pulse in progress
//   pending                    doses due but not yet served
//   missed_cnt                 saturating per-channel missed counters, ch0 in LSBs
// Build option: define DOSE_MANUAL_EN to make rising edges of manual_req
// queue doses; otherwise manual_req is ignored.
module dose_scheduler
    import dose_pkg::*;
#(
    parameter int unsigned NCH       = 4,
    parameter int unsigned SLOTS     = 3,
    parameter int unsigned PULSE_SEC = 1,
    parameter int unsigned MISS_W    = 4
) (
    input  logic                     CLOCK_50,
    input  logic                     reset,
    input  logic                     sec_tick,
    input  logic [HOUR_W-1:0]        hours,
    input  logic [MIN_W-1:0]         minutes,
    input  logic [SEC_W-1:0]         seconds,
    input  logic                     cfg_we,
    input  logic [idx_w(NCH)-1:0]    cfg_ch,
    input  logic [idx_w(SLOTS)-1:0]  cfg_slot,
    input  logic                     cfg_en,
    input  logic [HOUR_W-1:0]        cfg_hour,
    input  logic [MIN_W-1:0]         cfg_min,
    input  logic [NCH-1:0]           manual_req,
    output logic [NCH-1:0]           dispense,
    output logic                     busy,
    output logic [NCH-1:0]           pending,
    output logic [NCH*MISS_W-1:0]    missed_cnt
);

    localparam int unsigned CH_W  = idx_w(NCH);
    localparam int unsigned TMR_W = 4;

    logic [NCH-1:0]    slot_due;
    logic [NCH-1:0]    manual_rise;
    logic [NCH-1:0]    due;
    logic              match_tick;
    logic [NCH-1:0]    pend_nxt;
    logic [MISS_W-1:0] miss_q   [NCH];
    logic [MISS_W-1:0] miss_nxt [NCH];
    state_t            state;
    logic [CH_W-1:0]   rr_ptr;
    logic [CH_W-1:0]   grant_q;
    logic [CH_W-1:0]   grant_sel;
    logic [CH_W-1:0]   cand;
    logic              found;
    logic              grant_now;
    logic [TMR_W-1:0]  timer;

    for (genvar c = 0; c < NCH; c++) begin : g_ch
        dose_slot_match #(
            .SLOTS (SLOTS)
        ) u_match (
            .clk     (CLOCK_50),
            .reset   (reset),
            .we      (cfg_we && (cfg_ch == CH_W'(c))),
            .slot    (cfg_slot),
            .en      (cfg_en),
            .hour    (cfg_hour),
            .min     (cfg_min),
            .hours   (hours),
            .minutes (minutes),
            .due     (slot_due[c])
        );
        assign missed_cnt[c*MISS_W +: MISS_W] = miss_q[c];
    end

`ifdef DOSE_MANUAL_EN
    logic [NCH-1:0] manual_q;

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            manual_q <= '0;
        end else begin
            manual_q <= manual_req;
        end
    end

    assign manual_rise = manual_req & ~manual_q;
`else
    logic unused_manual;

    assign unused_manual = ^manual_req;
    assign manual_rise   = '0;
`endif

    assign match_tick = sec_tick && (seconds == '0);
    assign due        = ({NCH{match_tick}} & slot_due) | manual_rise;
    assign grant_now  = (state == IDLE) && (|pending);

    // First pending channel at or after the round-robin pointer, wrapping.
    always_comb begin
        grant_sel = '0;
        cand      = '0;
        found     = 1'b0;
        for (int unsigned i = 0; i < NCH; i++) begin
            cand = CH_W'((32'(rr_ptr) + i) % NCH);
            if (!found && pending[cand]) begin
                found     = 1'b1;
                grant_sel = cand;
            end
        end
    end

    // The grant clears its bit first; a dose due on the granted channel in the
    // same cycle is a fresh dose and re-queues without counting as missed.
    always_comb begin
        pend_nxt = pending;
        miss_nxt = miss_q;
        if (grant_now) begin
            pend_nxt[grant_sel] = 1'b0;
        end
        for (int unsigned c = 0; c < NCH; c++) begin
            if (due[c]) begin
                if (pending[c] && !(grant_now && (32'(grant_sel) == c)) &&
                    (miss_q[c] != '1)) begin
                    miss_nxt[c] = miss_q[c] + MISS_W'(1);
                end
                pend_nxt[c] = 1'b1;
            end
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            pending <= '0;
            for (int unsigned c = 0; c < NCH; c++) begin
                miss_q[c] <= '0;
            end
        end else begin
            pending <= pend_nxt;
            miss_q  <= miss_nxt;
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state    <= IDLE;
            rr_ptr   <= '0;
            grant_q  <= '0;
            timer    <= '0;
            dispense <= '0;
            busy     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (|pending) begin
                        grant_q  <= grant_sel;
                        dispense <= NCH'(1) << grant_sel;
                        busy     <= 1'b1;
                        timer    <= TMR_W'(PULSE_SEC);
                        state    <= PULSE;
                    end
                end
                PULSE: begin
                    if (sec_tick) begin
                        timer <= timer - TMR_W'(1);
                        if (timer <= TMR_W'(1)) begin
                            dispense <= '0;
                            busy     <= 1'b0;
                            rr_ptr   <= (grant_q == CH_W'(NCH - 1)) ? '0 : grant_q + CH_W'(1);
                            state    <= GAP;
                        end
                    end
                end
                GAP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
